// File: rtl/loop_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loop_counter_pkg
// Purpose  : Shared types and helpers for the nested-loop index generator.
//            - state_t       : traversal FSM encoding (IDLE, RUN, DONE)
//            - c_DEFAULT_*   : default per-level width and level count
//            - level_of()    : extracts one level field from a packed bus
// Config   : none (LOOP_COUNTER_DOWN_EN affects the other files only)
// Revision : 1.0 - initial release
// ============================================================================
package loop_counter_pkg;

  localparam int c_DEFAULT_WIDTH  = 4;
  localparam int c_DEFAULT_LEVELS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns field lvl (each width bits) of a packed bus, zero-extended to 64
  // bits. Callers size-cast the result down to their own level width.
  function automatic logic [63:0] level_of(input logic [63:0] packed_bus,
                                           input int unsigned width,
                                           input int unsigned lvl);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (packed_bus >> (lvl * width)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loop_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : loop_counter_if
// Purpose  : Traversal handshake and index bus between a controller
//            (master) and loop_counter (slave).
//            start/limit/adv/dir : controller -> counter
//            idx/wrap/busy/done  : counter -> controller
// Config   : LOOP_COUNTER_DOWN_EN adds the dir signal.
// Revision : 1.0 - initial release
// ============================================================================
interface loop_counter_if #(
  parameter int WIDTH  = 4,
  parameter int LEVELS = 3
);
  logic                    start;
  logic [LEVELS*WIDTH-1:0] limit;
  logic                    adv;
`ifdef LOOP_COUNTER_DOWN_EN
  logic                    dir;
`endif
  logic [LEVELS*WIDTH-1:0] idx;
  logic [LEVELS-1:0]       wrap;
  logic                    busy;
  logic                    done;

  modport master (
    output start, limit, adv,
`ifdef LOOP_COUNTER_DOWN_EN
    output dir,
`endif
    input  idx, wrap, busy, done
  );

  modport slave (
    input  start, limit, adv,
`ifdef LOOP_COUNTER_DOWN_EN
    input  dir,
`endif
    output idx, wrap, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/loop_counter_level_counter.sv
`default_nettype none
// ============================================================================
// Module   : level_counter
// Purpose  : One loop level: index register, latched inclusive limit, and
//            step/reload logic.
//            clk, rst(active-low async)
//            load    : latch lim_in and load the start value
//            lim_in  : inclusive maximum for this level
//            step_en : advance this level (carry-in from lower levels)
//            dir     : 1 = count down (LOOP_COUNTER_DOWN_EN only)
//            idx     : current index
//            at_end  : index equals the end value for the current direction
// Config   : LOOP_COUNTER_DOWN_EN enables the dir port and down counting.
// Revision : 1.0 - initial release
// ============================================================================
module level_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] lim_in,
  input  logic             step_en,
`ifdef LOOP_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] idx,
  output logic             at_end
);

  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_lim;
  logic [WIDTH-1:0] w_start;
  logic [WIDTH-1:0] w_end;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_step_val;

`ifdef LOOP_COUNTER_DOWN_EN
  // At load time r_lim is not yet valid, so the start value comes from lim_in.
  assign w_start    = dir ? r_lim  : '0;
  assign w_end      = dir ? '0     : r_lim;
  assign w_load_val = dir ? lim_in : '0;
  assign w_step_val = dir ? (r_idx - WIDTH'(1)) : (r_idx + WIDTH'(1));
`else
  assign w_start    = '0;
  assign w_end      = r_lim;
  assign w_load_val = '0;
  assign w_step_val = r_idx + WIDTH'(1);
`endif

  assign at_end = (r_idx == w_end);
  assign idx    = r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
      r_lim <= '0;
    end else if (load) begin
      r_lim <= lim_in;
      r_idx <= w_load_val;
    end else if (step_en) begin
      // Reloading at the end value keeps lim = 2^WIDTH-1 free of overflow.
      r_idx <= at_end ? w_start : w_step_val;
    end
  end

endmodule
`default_nettype wire

// File: rtl/loop_counter.sv
`default_nettype none
// ============================================================================
// Module   : loop_counter
// Purpose  : Nested-loop index generator. LEVELS cascaded level_counter
//            instances with ripple carry from level 0 (innermost) upward,
//            framed by a start/busy/done traversal handshake.
//            clk     : rising-edge clock
//            rst     : asynchronous active-low reset
//            bus     : loop_counter_if.slave (start, limit, adv, [dir],
//                      idx, wrap, busy, done)
// Config   : LOOP_COUNTER_DOWN_EN adds dir (sampled at start) and
//            per-traversal down counting.
// Revision : 1.0 - initial release
// ============================================================================
module loop_counter
  import loop_counter_pkg::*;
#(
  parameter int WIDTH  = c_DEFAULT_WIDTH,
  parameter int LEVELS = c_DEFAULT_LEVELS
) (
  input  logic          clk,
  input  logic          rst,
  loop_counter_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_adv;
  logic              w_last;
  logic [LEVELS-1:0] w_at_end;
  logic [LEVELS-1:0] w_carry;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_adv    = (r_state == RUN)  && bus.adv;

`ifdef LOOP_COUNTER_DOWN_EN
  logic r_dir;
  logic w_dir;

  // In IDLE the levels must see the incoming dir so load picks the right
  // start value; afterwards the latched copy governs the traversal.
  assign w_dir = (r_state == IDLE) ? bus.dir : r_dir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir <= 1'b0;
    end else if (w_accept) begin
      r_dir <= bus.dir;
    end
  end
`endif

  // w_carry[i]: every level below i sits at its end value.
  assign w_carry[0] = 1'b1;
  generate
    for (genvar i = 1; i < LEVELS; i++) begin : g_carry
      assign w_carry[i] = w_carry[i-1] & w_at_end[i-1];
    end
  endgenerate

  assign w_last   = w_carry[LEVELS-1] & w_at_end[LEVELS-1];
  assign bus.wrap = {LEVELS{w_adv}} & w_carry & w_at_end;

  generate
    for (genvar i = 0; i < LEVELS; i++) begin : g_level
      level_counter #(
        .WIDTH (WIDTH)
      ) u_level (
        .clk     (clk),
        .rst     (rst),
        .load    (w_accept),
        .lim_in  (WIDTH'(level_of(64'(bus.limit), WIDTH, i))),
        .step_en (w_adv & w_carry[i]),
`ifdef LOOP_COUNTER_DOWN_EN
        .dir     (w_dir),
`endif
        .idx     (bus.idx[i*WIDTH +: WIDTH]),
        .at_end  (w_at_end[i])
      );
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_adv && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_loop_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_counter
// Purpose  : Directed self-checking bench for loop_counter (WIDTH=4,
//            LEVELS=3). Expected index sequences come from nested loops.
// Config   : LOOP_COUNTER_DOWN_EN enables the down-count scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  loop_counter_if #(.WIDTH(4), .LEVELS(3)) bus ();

  loop_counter #(.WIDTH(4), .LEVELS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.idx !== 12'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: idx=%h busy=%b done=%b wrap=%b, want 000/0/0/000",
               bus.idx, bus.busy, bus.done, bus.wrap);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic_sweep();
    int n;
    int cycles;
    logic [11:0] exp_idx;
    logic [2:0]  exp_wrap;
    bus.limit = 12'h213;
    bus.start = 1'b1;
    bus.adv   = 1'b0;
    tick();
    bus.start = 1'b0;
    cycles = 0;
    checks++;
    if (bus.busy !== 1'b1 || bus.idx !== 12'h000) begin
      errors++;
      $display("FAIL sweep_start: busy=%b idx=%h want 1/000", bus.busy, bus.idx);
    end
    tick();
    cycles++;
    checks++;
    if (bus.idx !== 12'h000 || bus.wrap !== 3'b000) begin
      errors++;
      $display("FAIL sweep_hold: idx=%h wrap=%b want 000/000", bus.idx, bus.wrap);
    end
    bus.adv = 1'b1;
    #1;
    n = 0;
    for (int a = 0; a <= 2; a++)
      for (int b = 0; b <= 1; b++)
        for (int c = 0; c <= 3; c++) begin
          exp_idx  = {4'(a), 4'(b), 4'(c)};
          exp_wrap = {(c == 3 && b == 1 && a == 2), (c == 3 && b == 1), (c == 3)};
          checks++;
          if (bus.idx !== exp_idx || bus.wrap !== exp_wrap || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_step%0d: idx=%h wrap=%b done=%b want %h/%b/0",
                     n, bus.idx, bus.wrap, bus.done, exp_idx, exp_wrap);
          end
          n++;
          tick();
          cycles++;
        end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.idx !== 12'h000 || cycles != 25 || n != 24) begin
      errors++;
      $display("FAIL sweep_done: done=%b busy=%b idx=%h cycles=%0d advs=%0d want 1/0/000/25/24",
               bus.done, bus.busy, bus.idx, cycles, n);
    end
    bus.adv = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done_pulse: done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
  endtask

  // Random stalls, with start pulses and limit changes during RUN.
  task automatic test_stall();
    int n;
    int stalls;
    logic [11:0] exp_idx;
    bus.limit = 12'h213;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    for (int a = 0; a <= 2; a++)
      for (int b = 0; b <= 1; b++)
        for (int c = 0; c <= 3; c++) begin
          exp_idx = {4'(a), 4'(b), 4'(c)};
          stalls = $urandom_range(0, 2);
          for (int s = 0; s < stalls; s++) begin
            bus.adv   = 1'b0;
            bus.start = 1'($urandom_range(0, 1));
            bus.limit = 12'($urandom_range(0, 4095));
            #1;
            checks++;
            if (bus.wrap !== 3'b000) begin
              errors++;
              $display("FAIL stall_wrap%0d: wrap=%b want 000", n, bus.wrap);
            end
            tick();
            checks++;
            if (bus.idx !== exp_idx || bus.busy !== 1'b1) begin
              errors++;
              $display("FAIL stall_hold%0d: idx=%h busy=%b want %h/1", n, bus.idx, bus.busy, exp_idx);
            end
          end
          bus.start = 1'b0;
          bus.adv   = 1'b1;
          #1;
          checks++;
          if (bus.idx !== exp_idx) begin
            errors++;
            $display("FAIL stall_step%0d: idx=%h want %h", n, bus.idx, exp_idx);
          end
          n++;
          tick();
        end
    bus.adv = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.idx !== 12'h000) begin
      errors++;
      $display("FAIL stall_done: done=%b idx=%h want 1/000", bus.done, bus.idx);
    end
    tick();
  endtask

  task automatic test_degenerate();
    logic [11:0] exp_idx;
    logic [2:0]  exp_wrap;
    bus.limit = 12'h000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.adv   = 1'b1;
    #1;
    checks++;
    if (bus.wrap !== 3'b111 || bus.idx !== 12'h000) begin
      errors++;
      $display("FAIL zero_lim_wrap: wrap=%b idx=%h want 111/000", bus.wrap, bus.idx);
    end
    tick();
    bus.adv = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_lim_done: done=%b busy=%b want 1/0", bus.done, bus.busy);
    end
    tick();
    // Levels 0 and 1 constant, level 2 full range.
    bus.limit = 12'hF00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.adv   = 1'b1;
    #1;
    for (int a = 0; a <= 15; a++) begin
      exp_idx  = {4'(a), 8'h00};
      exp_wrap = {(a == 15), 2'b11};
      checks++;
      if (bus.idx !== exp_idx || bus.wrap !== exp_wrap || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL max_lim_step%0d: idx=%h wrap=%b done=%b want %h/%b/0",
                 a, bus.idx, bus.wrap, bus.done, exp_idx, exp_wrap);
      end
      tick();
    end
    bus.adv = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.idx !== 12'h000) begin
      errors++;
      $display("FAIL max_lim_done: done=%b idx=%h want 1/000", bus.done, bus.idx);
    end
    tick();
  endtask

  task automatic test_start_in_done();
    bus.limit = 12'h000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.adv   = 1'b1;
    tick();
    // Now in DONE: present start with a new limit for two cycles.
    bus.adv   = 1'b0;
    bus.start = 1'b1;
    bus.limit = 12'h001;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.idx !== 12'h000) begin
      errors++;
      $display("FAIL done_start_next: busy=%b idx=%h want 1/000", bus.busy, bus.idx);
    end
    bus.adv = 1'b1;
    tick();
    checks++;
    if (bus.idx !== 12'h001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL done_start_lim: idx=%h busy=%b want 001/1", bus.idx, bus.busy);
    end
    tick();
    bus.adv = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_start_finish: done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.limit = 12'h0FF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.adv   = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    bus.adv = 1'b1;
    checks++;
    if (bus.idx !== 12'h025 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre: idx=%h busy=%b want 025/1", bus.idx, bus.busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.idx !== 12'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wrap !== 3'b000) begin
      errors++;
      $display("FAIL midrun_async: idx=%h busy=%b done=%b wrap=%b want 000/0/0/000",
               bus.idx, bus.busy, bus.done, bus.wrap);
    end
    bus.adv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL midrun_no_done%0d: done=%b want 0", i, bus.done);
      end
    end
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.idx !== 12'h000) begin
      errors++;
      $display("FAIL midrun_idle: busy=%b done=%b idx=%h want 0/0/000", bus.busy, bus.done, bus.idx);
    end
  endtask

`ifdef LOOP_COUNTER_DOWN_EN
  task automatic test_down();
    int n;
    logic [11:0] exp_idx;
    logic [2:0]  exp_wrap;
    bus.limit = 12'h121;
    bus.dir   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    checks++;
    if (bus.idx !== 12'h121 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL down_start: idx=%h busy=%b want 121/1", bus.idx, bus.busy);
    end
    bus.adv = 1'b1;
    #1;
    n = 0;
    for (int a = 1; a >= 0; a--)
      for (int b = 2; b >= 0; b--)
        for (int c = 1; c >= 0; c--) begin
          exp_idx  = {4'(a), 4'(b), 4'(c)};
          exp_wrap = {(c == 0 && b == 0 && a == 0), (c == 0 && b == 0), (c == 0)};
          checks++;
          if (bus.idx !== exp_idx || bus.wrap !== exp_wrap) begin
            errors++;
            $display("FAIL down_step%0d: idx=%h wrap=%b want %h/%b",
                     n, bus.idx, bus.wrap, exp_idx, exp_wrap);
          end
          n++;
          tick();
        end
    bus.adv = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.idx !== 12'h121 || n != 12) begin
      errors++;
      $display("FAIL down_done: done=%b idx=%h advs=%0d want 1/121/12", bus.done, bus.idx, n);
    end
    tick();
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.adv   = 1'b0;
    bus.limit = 12'h000;
`ifdef LOOP_COUNTER_DOWN_EN
    bus.dir   = 1'b0;
`endif
    test_reset();
    test_basic_sweep();
    test_stall();
    test_degenerate();
    test_start_in_done();
    test_reset_mid_run();
`ifdef LOOP_COUNTER_DOWN_EN
    test_down();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
